// File: rtl/b2bd_pkg.sv
// Shared types and constants for the b2bd_seq double-dabble converter.
package b2bd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Smallest digit count able to hold the largest magnitude the converter can see.
  function automatic int min_digits(input int bin_w, input bit signed_mode);
    logic [127:0] maxv;
    logic [127:0] p;
    int d;
    maxv = signed_mode ? (128'd1 << (bin_w - 1)) : ((128'd1 << bin_w) - 128'd1);
    p = 128'd1;
    d = 0;
    for (int i = 0; i < 38; i++) begin
      if (p <= maxv) begin
        p = p * 128'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/b2bd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift {BCD,bin} left by one.
module b2bd_dabble_step
  import b2bd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic [BCD_W*DIGITS+BIN_W-1:0] vec_i,
  output logic [BCD_W*DIGITS+BIN_W-1:0] vec_o
);

  logic [BCD_W*DIGITS-1:0]       adj_bcd;
  logic [BCD_W*DIGITS+BIN_W-1:0] adj_vec;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [BCD_W-1:0] digit;
    assign digit = vec_i[BIN_W + BCD_W*gi +: BCD_W];
    assign adj_bcd[BCD_W*gi +: BCD_W] = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

  assign adj_vec = {adj_bcd, vec_i[BIN_W-1:0]};
  assign vec_o   = adj_vec << 1;

endmodule

// File: rtl/b2bd_seq.sv
// Handshaked binary-to-BCD converter, one double-dabble iteration per clock.
// Define B2BD_SIGNED_EN to treat bc as two's complement and report the sign on neg.
module b2bd_seq
  import b2bd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BIN_W-1:0]          bc,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [BCD_W*DIGITS-1:0]   bdc,
  output logic                      neg,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int SR_W     = BCD_BITS + BIN_W;
  localparam int CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  logic             sign;
  logic [BIN_W-1:0] mag;

`ifdef B2BD_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
  assign sign = bc[BIN_W-1];
  // Negating the most negative value wraps to 2**(BIN_W-1), which is the correct unsigned magnitude.
  assign mag  = sign ? (~bc + BIN_W'(1)) : bc;
`else
  localparam bit SIGNED_MODE = 1'b0;
  assign sign = 1'b0;
  assign mag  = bc;
`endif

  if (BIN_W < 2) begin : g_bad_width
    $error("b2bd_seq: BIN_W must be at least 2");
  end
  if (DIGITS < min_digits(BIN_W, SIGNED_MODE)) begin : g_bad_digits
    $error("b2bd_seq: DIGITS too small for BIN_W");
  end

  state_e           state_q, state_d;
  logic [SR_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [SR_W-1:0]  step_vec;

  b2bd_dabble_step #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_step (
    .vec_i (sreg_q),
    .vec_o (step_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = {{BCD_BITS{1'b0}}, mag};
          cnt_d   = '0;
          neg_d   = sign;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = step_vec;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // The BCD half of the shift register is the result once DONE is reached.
  assign bdc = sreg_q[SR_W-1 -: BCD_BITS];
  assign neg = neg_q;

endmodule
